// File: rtl/logic_unit_scheduler_pkg.sv
// Shared types and constant helpers for the bit-serial logic unit scheduler.
package logic_sched_pkg;

    typedef enum logic [1:0] {
        OP_AND  = 2'b00,
        OP_OR   = 2'b01,
        OP_XOR  = 2'b10,
        OP_NAND = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    // Ceiling log2, never below 1 so index vectors always have at least one bit.
    function automatic int clog2(input int v);
        int r;
        int x;
        r = 0;
        x = v - 1;
        while (x > 0) begin
            r = r + 1;
            x = x >> 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/logic_unit_scheduler_bit_unit.sv
// Shared 1-bit logic gate: combinational AND/OR/XOR/NAND selected by op.
module logic_bit_unit
    import logic_sched_pkg::*;
(
    input  logic       a,
    input  logic       b,
    input  logic [1:0] op,
    output logic       y
);

    always_comb begin
        case (op_t'(op))
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_NAND: y = ~(a & b);
            default: y = a & b;
        endcase
    end

endmodule

// File: rtl/logic_unit_scheduler.sv
// Round-robin scheduler that time-shares one bit-serial logic gate among NREQ
// requesters, returning LSB-aligned results through a valid/ready port.
module logic_unit_scheduler
    import logic_sched_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    localparam int IDW  = clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [2*NREQ-1:0]     req_op,
    input  logic [WIDTH*NREQ-1:0] req_a,
    input  logic [WIDTH*NREQ-1:0] req_b,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [IDW-1:0]        res_id,
    output logic [WIDTH-1:0]      res_data,
    output logic                  busy
);

    localparam int CW = clog2(WIDTH);

    state_t           state;
    state_t           state_nx;
    logic [IDW-1:0]   last;
    logic [IDW-1:0]   winner;
    logic [IDW-1:0]   idx;
    logic             found;
    logic             accept;
    logic [1:0]       sel_op;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    op_t              op_q;
    logic [CW-1:0]    cnt;
    logic             gate_y;

    // Walk the ring from the far end back to last+1 so the nearest valid
    // requester after the previous winner overrides every later candidate.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = '0;
        for (int k = NREQ; k >= 1; k--) begin
            idx = IDW'((int'(last) + k) % NREQ);
            if (req_valid[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        sel_op = '0;
        sel_a  = '0;
        sel_b  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (winner == IDW'(i)) begin
                sel_op = req_op[2*i +: 2];
                sel_a  = req_a[WIDTH*i +: WIDTH];
                sel_b  = req_b[WIDTH*i +: WIDTH];
            end
        end
    end

    assign accept    = (state == IDLE) && found;
    assign req_ready = accept ? (NREQ'(1) << winner) : '0;
    assign res_valid = (state == DONE);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (found) state_nx = RUN;
            RUN:     if (cnt == CW'(WIDTH - 1)) state_nx = DONE;
            DONE:    if (res_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last     <= IDW'(NREQ - 1);
            cnt      <= '0;
            res_id   <= '0;
            res_data <= '0;
        end else if (accept) begin
            last   <= winner;
            res_id <= winner;
            cnt    <= '0;
        end else if (state == RUN) begin
            cnt      <= cnt + 1'b1;
            res_data <= {gate_y, res_data[WIDTH-1:1]};
        end
    end

    // Operand latches only matter while RUN, so they carry no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_q  <= sel_a;
            b_q  <= sel_b;
            op_q <= op_t'(sel_op);
        end
    end

    logic_bit_unit u_gate (
        .a  (a_q[cnt]),
        .b  (b_q[cnt]),
        .op (op_q),
        .y  (gate_y)
    );

endmodule

// File: tb/tb_logic_unit_scheduler.sv
// Scoreboard bench for logic_unit_scheduler with directed, hand-computed vectors.
module tb_logic_unit_scheduler;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;

    logic                  clk;
    logic                  rst_n;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [2*NREQ-1:0]     req_op;
    logic [WIDTH*NREQ-1:0] req_a;
    logic [WIDTH*NREQ-1:0] req_b;
    logic                  res_valid;
    logic                  res_ready;
    logic [1:0]            res_id;
    logic [WIDTH-1:0]      res_data;
    logic                  busy;

    logic_unit_scheduler #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_id    (res_id),
        .res_data  (res_data),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] id;
        logic [7:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   g_id[$];
    int   g_cyc[$];
    int   total = 0;
    int   bad   = 0;
    int   cycle = 0;
    int   last_acc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    task automatic set_req(input int i, input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        req_op[2*i +: 2] = op;
        req_a[8*i +: 8]  = a;
        req_b[8*i +: 8]  = b;
    endtask

    task automatic push(input logic [1:0] id, input logic [7:0] data);
        exp_t e;
        e.id   = id;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic wait_grant(output logic [3:0] g);
        g = '0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (req_ready != '0) begin
                g = req_ready;
                break;
            end
        end
        if (g == '0) check("grant_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_idle();
        int n;
        for (n = 0; n < 200; n++) begin
            @(negedge clk);
            if (!busy) break;
        end
        if (n == 200) check("idle_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_res_valid();
        int n;
        for (n = 0; n < 200; n++) begin
            @(negedge clk);
            if (res_valid) break;
        end
        if (n == 200) check("valid_timeout", 32'd0, 32'd1);
    endtask

    // Raise one request, check its grant strobe, drop it after the accept edge.
    task automatic issue(input int i, input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] res, input bit expect_res);
        logic [3:0] g;
        set_req(i, op, a, b);
        if (expect_res) push(2'(i), res);
        @(posedge clk);
        #1 req_valid[i] = 1'b1;
        wait_grant(g);
        check("grant_id", {28'd0, g}, 32'd1 << i);
        @(posedge clk);
        #1 req_valid[i] = 1'b0;
    endtask

    initial forever begin
        @(posedge clk);
        cycle++;
    end

    // Grant monitor.
    initial forever begin
        @(negedge clk);
        if (rst_n && req_ready != '0) begin
            int w;
            w = -1;
            for (int k = 0; k < NREQ; k++) if (req_ready[k]) w = k;
            g_id.push_back(w);
            g_cyc.push_back(cycle);
            last_acc = cycle;
        end
    end

    // Result monitor: latency from accept and scoreboard comparison.
    initial begin
        logic prev_v;
        exp_t e;
        prev_v = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && res_valid && !prev_v)
                check("latency", 32'(cycle - last_acc), 32'(WIDTH + 1));
            prev_v = res_valid;
            if (rst_n && res_valid && res_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_result", {30'd0, res_id}, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("res_id", {30'd0, res_id}, {30'd0, e.id});
                    check("res_data", {24'd0, res_data}, {24'd0, e.data});
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] g;
        int         cnt3;
        rst_n     = 1'b0;
        req_valid = '0;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        res_ready = 1'b1;

        @(negedge clk);
        check("rst_req_ready", {28'd0, req_ready}, 32'd0);
        check("rst_res_valid", {31'd0, res_valid}, 32'd0);
        check("rst_res_id", {30'd0, res_id}, 32'd0);
        check("rst_res_data", {24'd0, res_data}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Single request from requester 2.
        issue(2, 2'b00, 8'hF0, 8'h3C, 8'h30, 1'b1);
        @(negedge clk);
        check("ready_one_cycle", {28'd0, req_ready}, 32'd0);
        wait_idle();

        // Every opcode from requester 0.
        issue(0, 2'b00, 8'hA5, 8'h0F, 8'h05, 1'b1); wait_idle();
        issue(0, 2'b01, 8'hA5, 8'h0F, 8'hAF, 1'b1); wait_idle();
        issue(0, 2'b10, 8'hA5, 8'h0F, 8'hAA, 1'b1); wait_idle();
        issue(0, 2'b11, 8'hA5, 8'h0F, 8'hFA, 1'b1); wait_idle();

        // Round-robin with all four requesters held valid from reset.
        @(posedge clk);
        #1 rst_n = 1'b0;
        set_req(0, 2'b00, 8'hFF, 8'h12);
        set_req(1, 2'b01, 8'h01, 8'h80);
        set_req(2, 2'b10, 8'hFF, 8'h0F);
        set_req(3, 2'b11, 8'hFF, 8'h00);
        push(2'd0, 8'h12); push(2'd1, 8'h81); push(2'd2, 8'hF0); push(2'd3, 8'hFF); push(2'd0, 8'h12);
        req_valid = 4'b1111;
        g_id.delete();
        g_cyc.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int n = 0; n < 80 && g_id.size() < 5; n++) @(negedge clk);
        @(posedge clk);
        #1 req_valid = '0;
        check("rr_count", 32'(g_id.size()), 32'd5);
        if (g_id.size() >= 5) begin
            check("rr_g0", 32'(g_id[0]), 32'd0);
            check("rr_g1", 32'(g_id[1]), 32'd1);
            check("rr_g2", 32'(g_id[2]), 32'd2);
            check("rr_g3", 32'(g_id[3]), 32'd3);
            check("rr_g4", 32'(g_id[4]), 32'd0);
            for (int k = 1; k < 5; k++)
                check("rr_spacing", 32'(g_cyc[k] - g_cyc[k-1]), 32'(WIDTH + 2));
        end
        wait_idle();

        // Backpressure: DONE held for 20 cycles with requester 1 waiting.
        @(posedge clk);
        #1 res_ready = 1'b0;
        issue(0, 2'b10, 8'h3C, 8'hFF, 8'hC3, 1'b1);
        set_req(1, 2'b00, 8'hAA, 8'hFF);
        push(2'd1, 8'hAA);
        req_valid[1] = 1'b1;
        wait_res_valid();
        for (int n = 0; n < 20; n++) begin
            check("bp_hold", {17'd0, res_valid, res_id, res_data, req_ready}, {17'd0, 1'b1, 2'd0, 8'hC3, 4'b0000});
            @(negedge clk);
        end
        @(posedge clk);
        #1 res_ready = 1'b1;
        @(negedge clk);
        check("bp_release_wait", {28'd0, req_ready}, 32'd0);
        @(negedge clk);
        check("bp_release_grant", {28'd0, req_ready}, 32'b0010);
        @(posedge clk);
        #1 req_valid[1] = 1'b0;
        wait_idle();

        // Reset during RUN cycle 4 discards the operation.
        issue(1, 2'b01, 8'h12, 8'h34, 8'h00, 1'b0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_valid", {31'd0, res_valid}, 32'd0);
        set_req(0, 2'b11, 8'h0F, 8'h0F);
        set_req(3, 2'b00, 8'hFF, 8'hFF);
        push(2'd0, 8'hF0);
        req_valid = 4'b1001;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        wait_grant(g);
        check("midrst_first_grant", {28'd0, g}, 32'b0001);
        @(posedge clk);
        #1 req_valid = '0;
        wait_idle();

        // Requester 3 withdraws while the block is busy.
        g_id.delete();
        issue(1, 2'b10, 8'h55, 8'h0F, 8'h5A, 1'b1);
        set_req(3, 2'b01, 8'h11, 8'h22);
        @(posedge clk);
        #1 req_valid[3] = 1'b1;
        wait_res_valid();
        #1 req_valid[3] = 1'b0;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            check("wd_idle", {27'd0, busy, req_ready}, 32'd0);
        end
        cnt3 = 0;
        foreach (g_id[k]) if (g_id[k] == 3) cnt3++;
        check("wd_never_granted", 32'(cnt3), 32'd0);

        check("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
